// File: rtl/regwb_ctrl_pkg.sv
// Shared CPU definitions for the register-file writeback path.
// Contents:
//   REG_ADDR_W / REG_DATA_W - register file address and data widths
//   REG_ZERO                - hard-wired zero register index
//   isLiveRd()              - true when a destination produces a real write
package regwb_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Writes to the zero register are accepted but never reach the array.
  function automatic logic isLiveRd(input logic [REG_ADDR_W-1:0] rd);
    return (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/regwb_ctrl_fifo.sv
// regwb_fifo: circular buffer of secondary (long-latency) results.
// Each entry holds {rd, data, live}. A primary write to rd R marks every
// buffered entry with rd R stale; a push in the same cycle stays live
// because it is younger than that primary write.
// Ports:
//   clk, rst              - clock, async active-high reset
//   push, pushRd, pushData- enqueue request (caller guarantees !full)
//   pop                   - dequeue head (caller guarantees !empty)
//   killEn, killRd        - bulk stale-mark by destination match
//   matchRd1/2, match1/2  - live-entry lookup for the pending flags
//   headRd/headData/headLive, full, empty, count - buffer state
module regwb_fifo
  import regwb_ctrl_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushRd,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  input  logic              killEn,
  input  logic [ADDR_W-1:0] killRd,
  input  logic [ADDR_W-1:0] matchRd1,
  input  logic [ADDR_W-1:0] matchRd2,
  output logic              match1,
  output logic              match2,
  output logic [ADDR_W-1:0] headRd,
  output logic [DATA_W-1:0] headData,
  output logic              headLive,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] rdMem_r   [DEPTH];
  logic [DATA_W-1:0] dataMem_r [DEPTH];
  logic [DEPTH-1:0]  liveMem_r;
  logic [PTR_W-1:0]  wrPtr_r;
  logic [PTR_W-1:0]  rdPtr_r;
  logic [CNT_W-1:0]  count_r;

  // Payload storage; no reset needed because live bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem_r[wrPtr_r]   <= pushRd;
      dataMem_r[wrPtr_r] <= pushData;
    end
  end

  // Pointers, occupancy and live bits. Popped slots are cleared so that a
  // set live bit always implies an occupied slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      liveMem_r <= '0;
      wrPtr_r   <= '0;
      rdPtr_r   <= '0;
      count_r   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (killEn && (rdMem_r[i] == killRd)) liveMem_r[i] <= 1'b0;
      end
      if (pop) begin
        liveMem_r[rdPtr_r] <= 1'b0;
        rdPtr_r            <= rdPtr_r + PTR_W'(1);
      end
      // Placed after the kill loop so a same-cycle push survives the kill.
      if (push) begin
        liveMem_r[wrPtr_r] <= isLiveRd(pushRd);
        wrPtr_r            <= wrPtr_r + PTR_W'(1);
      end
      if (push && !pop) begin
        count_r <= count_r + CNT_W'(1);
      end else if (!push && pop) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Live-entry lookup for the two issue-stage read ports.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match1 = match1 | (liveMem_r[i] && (rdMem_r[i] == matchRd1));
      match2 = match2 | (liveMem_r[i] && (rdMem_r[i] == matchRd2));
    end
  end

  assign headRd   = rdMem_r[rdPtr_r];
  assign headData = dataMem_r[rdPtr_r];
  assign headLive = liveMem_r[rdPtr_r];
  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == CNT_W'(0));
  assign count    = count_r;

endmodule

// File: rtl/regwb_ctrl.sv
// regwb_ctrl: register-file write-port controller.
// Merges the in-order pipeline writeback (primary, unbuffered) with a
// long-latency result stream (secondary, valid/ready, buffered) into one
// registered write per cycle. Primary has priority until the buffer head
// has been blocked STARVE_MAX cycles, then primary is stalled for a cycle.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   pri_valid/pri_rd/pri_data, pri_stall - primary writeback
//   sec_valid/sec_rd/sec_data, sec_ready - secondary result stream
//   RegWrite/WriteRegister/WriteData  - register file write port
//   rd_addr1/2, fwd1/2_valid, fwd_data - forwarding of the in-flight write
//   pend1/2                           - live buffered result pending
module regwb_ctrl
  import regwb_ctrl_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pri_valid,
  input  logic [ADDR_W-1:0] pri_rd,
  input  logic [DATA_W-1:0] pri_data,
  output logic              pri_stall,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [ADDR_W-1:0] sec_rd,
  input  logic [DATA_W-1:0] sec_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              fwd1_valid,
  output logic              fwd2_valid,
  output logic [DATA_W-1:0] fwd_data,
  output logic              pend1,
  output logic              pend2
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  logic              regWrite_r;
  logic [ADDR_W-1:0] writeReg_r;
  logic [DATA_W-1:0] writeData_r;
  logic [SC_W-1:0]   starveCnt_r;
  logic              secReady_r;

  logic              priGrant_s, pop_s, push_s, priStall_s;
  logic [CNT_W-1:0]  countNext_s;
  logic              match1_s, match2_s;
  logic [ADDR_W-1:0] headRd_s;
  logic [DATA_W-1:0] headData_s;
  logic              headLive_s, full_s, empty_s;
  logic [CNT_W-1:0]  count_s;

  regwb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pushRd   (sec_rd),
    .pushData (sec_data),
    .pop      (pop_s),
    .killEn   (priGrant_s),
    .killRd   (pri_rd),
    .matchRd1 (rd_addr1),
    .matchRd2 (rd_addr2),
    .match1   (match1_s),
    .match2   (match2_s),
    .headRd   (headRd_s),
    .headData (headData_s),
    .headLive (headLive_s),
    .full     (full_s),
    .empty    (empty_s),
    .count    (count_s)
  );

  // Arbitration: primary wins unless stalled or writing r0; otherwise drain.
  always_comb begin
    priStall_s = (starveCnt_r == STARVE_LIM) && !empty_s;
    priGrant_s = !priStall_s && pri_valid && isLiveRd(pri_rd);
    pop_s      = !priGrant_s && !empty_s;
    push_s     = sec_valid && secReady_r && !full_s;
    if (push_s && !pop_s) begin
      countNext_s = count_s + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      countNext_s = count_s - CNT_W'(1);
    end else begin
      countNext_s = count_s;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_r  <= 1'b0;
      writeReg_r  <= '0;
      writeData_r <= '0;
    end else if (priGrant_s) begin
      regWrite_r  <= 1'b1;
      writeReg_r  <= pri_rd;
      writeData_r <= pri_data;
    end else if (pop_s && headLive_s) begin
      regWrite_r  <= 1'b1;
      writeReg_r  <= headRd_s;
      writeData_r <= headData_s;
    end else begin
      regWrite_r  <= 1'b0;
    end
  end

  // Starvation counter: counts cycles a non-empty buffer's head is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt_r <= '0;
    end else if (empty_s || pop_s) begin
      starveCnt_r <= '0;
    end else if (starveCnt_r != STARVE_LIM) begin
      starveCnt_r <= starveCnt_r + SC_W'(1);
    end
  end

  // Ready reflects next-cycle occupancy, so a pop never frees a slot early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      secReady_r <= 1'b0;
    end else begin
      secReady_r <= (countNext_s != CNT_W'(DEPTH));
    end
  end

  assign RegWrite      = regWrite_r;
  assign WriteRegister = writeReg_r;
  assign WriteData     = writeData_r;
  assign pri_stall     = priStall_s;
  assign sec_ready     = secReady_r;
  assign fwd_data      = writeData_r;
  assign fwd1_valid    = regWrite_r && (writeReg_r == rd_addr1) && isLiveRd(rd_addr1);
  assign fwd2_valid    = regWrite_r && (writeReg_r == rd_addr2) && isLiveRd(rd_addr2);
  assign pend1         = isLiveRd(rd_addr1) && match1_s;
  assign pend2         = isLiveRd(rd_addr2) && match2_s;

endmodule

// File: tb/tb_regwb_ctrl.sv
// Directed testbench for regwb_ctrl with hand-computed expectations.
module tb_regwb_ctrl;

  logic        clk;
  logic        rst;
  logic        pri_valid;
  logic [4:0]  pri_rd;
  logic [31:0] pri_data;
  logic        pri_stall;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_rd;
  logic [31:0] sec_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        fwd1_valid;
  logic        fwd2_valid;
  logic [31:0] fwd_data;
  logic        pend1;
  logic        pend2;

  int vecCnt = 0;
  int errCnt = 0;

  regwb_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pri_valid     (pri_valid),
    .pri_rd        (pri_rd),
    .pri_data      (pri_data),
    .pri_stall     (pri_stall),
    .sec_valid     (sec_valid),
    .sec_ready     (sec_ready),
    .sec_rd        (sec_rd),
    .sec_data      (sec_data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .fwd1_valid    (fwd1_valid),
    .fwd2_valid    (fwd2_valid),
    .fwd_data      (fwd_data),
    .pend1         (pend1),
    .pend2         (pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 2 time units past the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; pri_valid = 1'b0; pri_rd = 5'd0; pri_data = 32'h0;
    sec_valid = 1'b0; sec_rd = 5'd0; sec_data = 32'h0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;

    // Reset state
    #12;
    chkVal("rst_regwrite", RegWrite, 32'd0);
    chkVal("rst_wreg", WriteRegister, 32'd0);
    chkVal("rst_wdata", WriteData, 32'd0);
    chkVal("rst_stall", pri_stall, 32'd0);
    chkVal("rst_ready", sec_ready, 32'd0);
    rst = 1'b0;
    tick();
    chkVal("ready_after_rst", sec_ready, 32'd1);

    // Primary only
    pri_valid = 1'b1; pri_rd = 5'd5; pri_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
    tick();
    chkVal("p_regwrite", RegWrite, 32'd1);
    chkVal("p_wreg", WriteRegister, 32'd5);
    chkVal("p_wdata", WriteData, 32'hDEADBEEF);
    chkVal("p_fwd1", fwd1_valid, 32'd1);
    chkVal("p_fwddata", fwd_data, 32'hDEADBEEF);
    pri_valid = 1'b0;
    tick();
    chkVal("p_idle_regwrite", RegWrite, 32'd0);
    chkVal("p_idle_hold", WriteRegister, 32'd5);
    chkVal("p_idle_fwd1", fwd1_valid, 32'd0);

    // Secondary only: pend for one cycle, write two edges after push
    sec_valid = 1'b1; sec_rd = 5'd8; sec_data = 32'h11; rd_addr1 = 5'd8;
    tick();
    sec_valid = 1'b0;
    #1;
    chkVal("s_pend1", pend1, 32'd1);
    chkVal("s_nowrite", RegWrite, 32'd0);
    tick();
    chkVal("s_regwrite", RegWrite, 32'd1);
    chkVal("s_wreg", WriteRegister, 32'd8);
    chkVal("s_wdata", WriteData, 32'h11);
    chkVal("s_pend_clr", pend1, 32'd0);
    chkVal("s_fwd1", fwd1_valid, 32'd1);

    // Stale: buffered rd3=0xAA overwritten by primary rd3=0xBB
    sec_valid = 1'b1; sec_rd = 5'd3; sec_data = 32'hAA; rd_addr2 = 5'd3;
    tick();
    sec_valid = 1'b0; pri_valid = 1'b1; pri_rd = 5'd3; pri_data = 32'hBB;
    #1;
    chkVal("st_pend2", pend2, 32'd1);
    tick();
    chkVal("st_wdata", WriteData, 32'hBB);
    chkVal("st_pend2_clr", pend2, 32'd0);
    chkVal("st_fwd2", fwd2_valid, 32'd1);
    pri_valid = 1'b0;
    tick();
    chkVal("st_pop_nowrite", RegWrite, 32'd0);
    chkVal("st_hold_data", WriteData, 32'hBB);
    chkVal("st_ready", sec_ready, 32'd1);

    // Same-cycle push with matching rd stays live
    pri_valid = 1'b1; pri_rd = 5'd3; pri_data = 32'hCC;
    sec_valid = 1'b1; sec_rd = 5'd3; sec_data = 32'hDD;
    tick();
    chkVal("y_pri_wdata", WriteData, 32'hCC);
    chkVal("y_pend2", pend2, 32'd1);
    pri_valid = 1'b0; sec_valid = 1'b0;
    tick();
    chkVal("y_regwrite", RegWrite, 32'd1);
    chkVal("y_wdata", WriteData, 32'hDD);
    tick();

    // Starvation: fill while primary writes every cycle
    pri_valid = 1'b1; pri_rd = 5'd10; pri_data = 32'h100; sec_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sec_rd = 5'(20 + i); sec_data = 32'h200 + 32'(i);
      tick();
      chkVal("sv_pri_write", WriteRegister, 32'd10);
    end
    chkVal("sv_full_ready", sec_ready, 32'd0);
    sec_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chkVal("sv_stall", pri_stall, (j == 3) ? 32'd1 : 32'd0);
    end
    chkVal("sv_last_pri", WriteData, 32'h100);
    tick();
    chkVal("sv_drain_wreg", WriteRegister, 32'd20);
    chkVal("sv_drain_wdata", WriteData, 32'h200);
    chkVal("sv_stall_clr", pri_stall, 32'd0);
    chkVal("sv_ready_back", sec_ready, 32'd1);
    pri_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chkVal("sv_drain_wreg", WriteRegister, 32'(20 + k));
      chkVal("sv_drain_wdata", WriteData, 32'h200 + 32'(k));
    end
    tick();
    chkVal("sv_empty_nowrite", RegWrite, 32'd0);

    // Zero-register traffic never writes
    pri_valid = 1'b1; pri_rd = 5'd0; pri_data = 32'h55;
    sec_valid = 1'b1; sec_rd = 5'd0; sec_data = 32'h66;
    rd_addr1 = 5'd0;
    tick();
    chkVal("z_regwrite0", RegWrite, 32'd0);
    pri_valid = 1'b0; sec_valid = 1'b0;
    #1;
    chkVal("z_pend1", pend1, 32'd0);
    tick();
    chkVal("z_regwrite1", RegWrite, 32'd0);
    chkVal("z_hold_wreg", WriteRegister, 32'd23);
    chkVal("z_hold_wdata", WriteData, 32'h203);
    tick();
    chkVal("z_regwrite2", RegWrite, 32'd0);
    chkVal("z_ready", sec_ready, 32'd1);

    // Reset mid-operation with 3 buffered entries
    pri_valid = 1'b1; pri_rd = 5'd9; pri_data = 32'h900; sec_valid = 1'b1;
    rd_addr1 = 5'd12;
    for (int i = 0; i < 3; i++) begin
      sec_rd = 5'(12 + i); sec_data = 32'hC0 + 32'(i);
      tick();
    end
    chkVal("r_regwrite_pre", RegWrite, 32'd1);
    chkVal("r_pend_pre", pend1, 32'd1);
    rst = 1'b1;
    pri_valid = 1'b0; sec_valid = 1'b0;
    #1;
    chkVal("r_regwrite", RegWrite, 32'd0);
    chkVal("r_wreg", WriteRegister, 32'd0);
    chkVal("r_wdata", WriteData, 32'd0);
    chkVal("r_ready", sec_ready, 32'd0);
    chkVal("r_stall", pri_stall, 32'd0);
    chkVal("r_pend", pend1, 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chkVal("r_no_stale_write", RegWrite, 32'd0);
    end
    chkVal("r_ready_after", sec_ready, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
